// File: rtl/lift_sched_fsm.sv
// Single-car lift scheduler: collects up/down hall requests into pending bitmaps
// and sweeps the car in one direction until nothing is left ahead of it.
module lift_sched_fsm #(
  parameter int FLOORS     = 4,
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 3,
  localparam int FW        = (FLOORS > 2) ? $clog2(FLOORS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic [FW-1:0] req_floor,
  input  logic          req_dir,
  output logic          req_err,
  output logic [1:0]    dout,
  output logic [FW-1:0] cur_floor,
  output logic          door_open,
  output logic          done,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MOVE = 2'd1, S_DOOR = 2'd2} state_e;

  localparam logic       DIR_UP    = 1'b0;
  localparam logic       DIR_DN    = 1'b1;
  localparam logic [1:0] DOUT_UP   = 2'b00;
  localparam logic [1:0] DOUT_DN   = 2'b01;
  localparam logic [1:0] DOUT_STAY = 2'b10;

  localparam int MAXC = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_CYC - 1);
  localparam logic [CW-1:0] DOOR_LAST   = CW'(DOOR_CYC - 1);
  localparam logic [FW-1:0] TOP_FLOOR   = FW'(FLOORS - 1);

  state_e              state_q, state_d;
  logic [FW-1:0]       cur_floor_q, cur_floor_d;
  logic                dir_q, dir_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [FLOORS-1:0]   up_pend_q, up_pend_d;
  logic [FLOORS-1:0]   dn_pend_q, dn_pend_d;
  logic                srv_up_q, srv_up_d;
  logic                srv_dn_q, srv_dn_d;
  logic                req_err_q, req_err_d;

  logic [FLOORS-1:0]   any_pend;
  logic [FW-1:0]       next_floor;
  logic                clr_up, clr_dn;
  logic                req_ok, absorb;

  // True when any bit of pend lies strictly beyond floor in direction dir.
  function automatic logic pend_beyond(input logic [FLOORS-1:0] pend,
                                       input logic [FW-1:0]     floor,
                                       input logic              dir);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if ((dir == DIR_UP && i > int'(floor)) || (dir == DIR_DN && i < int'(floor)))
        hit = hit | pend[i];
    end
    return hit;
  endfunction

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_floor_q <= '0;
      dir_q       <= DIR_UP;
      cnt_q       <= '0;
      up_pend_q   <= '0;
      dn_pend_q   <= '0;
      srv_up_q    <= 1'b0;
      srv_dn_q    <= 1'b0;
      req_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      up_pend_q   <= up_pend_d;
      dn_pend_q   <= dn_pend_d;
      srv_up_q    <= srv_up_d;
      srv_dn_q    <= srv_dn_d;
      req_err_q   <= req_err_d;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    srv_up_d    = srv_up_q;
    srv_dn_d    = srv_dn_q;
    clr_up      = 1'b0;
    clr_dn      = 1'b0;
    next_floor  = cur_floor_q;
    any_pend    = up_pend_q | dn_pend_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (any_pend[cur_floor_q]) begin
          state_d = S_DOOR;
          clr_up  = up_pend_q[cur_floor_q];
          clr_dn  = dn_pend_q[cur_floor_q];
        end else if (pend_beyond(any_pend, cur_floor_q, DIR_UP) &&
                     (dir_q == DIR_UP || !pend_beyond(any_pend, cur_floor_q, DIR_DN))) begin
          dir_d   = DIR_UP;
          state_d = S_MOVE;
        end else if (pend_beyond(any_pend, cur_floor_q, DIR_DN)) begin
          dir_d   = DIR_DN;
          state_d = S_MOVE;
        end
      end

      S_MOVE: begin
        if (cnt_q == TRAVEL_LAST) begin
          cnt_d = '0;
          if (dir_q == DIR_UP && cur_floor_q != TOP_FLOOR)
            next_floor = cur_floor_q + 1'b1;
          else if (dir_q == DIR_DN && cur_floor_q != '0)
            next_floor = cur_floor_q - 1'b1;
          cur_floor_d = next_floor;
          if ((dir_q == DIR_UP) ? up_pend_q[next_floor] : dn_pend_q[next_floor]) begin
            state_d = S_DOOR;
            clr_up  = (dir_q == DIR_UP);
            clr_dn  = (dir_q == DIR_DN);
          end else if (!pend_beyond(any_pend, next_floor, dir_q)) begin
            // Sweep exhausted: turn around and serve both calls here.
            state_d = S_DOOR;
            dir_d   = ~dir_q;
            clr_up  = 1'b1;
            clr_dn  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DOOR: begin
        if (cnt_q == DOOR_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (clr_up || clr_dn) begin
      srv_up_d = clr_up;
      srv_dn_d = clr_dn;
    end
  end

  // A request matching a call being served right now (door opening or open) is
  // absorbed; any other valid request overrides a same-edge clear.
  always_comb begin
    up_pend_d = up_pend_q;
    dn_pend_d = dn_pend_q;
    if (clr_up) up_pend_d[cur_floor_d] = 1'b0;
    if (clr_dn) dn_pend_d[cur_floor_d] = 1'b0;

    req_ok = req_valid && (int'(req_floor) < FLOORS) &&
             !(req_dir == DIR_UP && req_floor == TOP_FLOOR) &&
             !(req_dir == DIR_DN && req_floor == '0);
    absorb = (req_floor == cur_floor_d) &&
             ((req_dir == DIR_UP) ? (clr_up || (state_q == S_DOOR && srv_up_q))
                                  : (clr_dn || (state_q == S_DOOR && srv_dn_q)));
    if (req_ok && !absorb) begin
      if (req_dir == DIR_UP) up_pend_d[req_floor] = 1'b1;
      else                   dn_pend_d[req_floor] = 1'b1;
    end
    req_err_d = req_valid && !req_ok;
  end

  always_comb begin
    dout      = DOUT_STAY;
    door_open = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_MOVE:  dout = (dir_q == DIR_DN) ? DOUT_DN : DOUT_UP;
      S_DOOR: begin
        door_open = 1'b1;
        done      = (cnt_q == DOOR_LAST);
      end
      default: ;
    endcase
    busy      = (state_q != S_IDLE) || (|up_pend_q) || (|dn_pend_q);
    cur_floor = cur_floor_q;
    req_err   = req_err_q;
  end

endmodule

// File: tb/tb_lift_sched_fsm.sv
// Directed bench for lift_sched_fsm (4 floors, 4-cycle travel, 3-cycle door),
// plus a 5-floor instance for requests beyond the top floor.
module tb_lift_sched_fsm;

  localparam logic [1:0] UP = 2'b00;
  localparam logic [1:0] DN = 2'b01;
  localparam logic [1:0] ST = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_floor = '0;
  logic       req_dir = 1'b0;
  logic       req_err, door_open, done, busy;
  logic [1:0] dout, cur_floor;

  logic       r5_valid = 1'b0;
  logic [2:0] r5_floor = '0;
  logic       r5_dir = 1'b0;
  logic       r5_err, r5_door, r5_done, r5_busy;
  logic [1:0] r5_dout;
  logic [2:0] r5_cur;

  always #5 clk = ~clk;

  lift_sched_fsm #(.FLOORS(4), .TRAVEL_CYC(4), .DOOR_CYC(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_floor(req_floor),
    .req_dir(req_dir), .req_err(req_err), .dout(dout), .cur_floor(cur_floor),
    .door_open(door_open), .done(done), .busy(busy)
  );

  lift_sched_fsm #(.FLOORS(5), .TRAVEL_CYC(4), .DOOR_CYC(3)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .req_valid(r5_valid), .req_floor(r5_floor),
    .req_dir(r5_dir), .req_err(r5_err), .dout(r5_dout), .cur_floor(r5_cur),
    .door_open(r5_door), .done(r5_done), .busy(r5_busy)
  );

  typedef struct {
    logic       rst;
    logic       vld;
    logic [1:0] fl;
    logic       dr;
    logic [1:0] dout;
    logic [1:0] floor;
    logic       door;
    logic       done;
    logic       err;
    logic       busy;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  int   stop_floor[$];
  int   door_len[$];
  int   done_cnt, bad_cnt, up_cnt, first_up_floor;

  function automatic vec_t mk(input logic rst, input logic vld, input logic [1:0] fl,
                              input logic dr, input logic [1:0] o_dout,
                              input logic [1:0] o_floor, input logic o_door,
                              input logic o_done, input logic o_err, input logic o_busy);
    vec_t v;
    v.rst = rst; v.vld = vld; v.fl = fl; v.dr = dr;
    v.dout = o_dout; v.floor = o_floor; v.door = o_door;
    v.done = o_done; v.err = o_err; v.busy = o_busy;
    return v;
  endfunction

  function automatic logic [7:0] obs();
    return {dout, cur_floor, door_open, done, req_err, busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] f, input logic d);
    @(negedge clk);
    req_valid = 1'b1; req_floor = f; req_dir = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Watches the main car for a fixed number of cycles, logging stops and pulses.
  task automatic monitor(input int cycles);
    logic prev_door;
    prev_door = 1'b0;
    stop_floor.delete();
    door_len.delete();
    done_cnt = 0; bad_cnt = 0; up_cnt = 0; first_up_floor = -1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (door_open && !prev_door) begin
        stop_floor.push_back(int'(cur_floor));
        door_len.push_back(0);
      end
      if (door_open) door_len[door_len.size()-1]++;
      if (done) done_cnt++;
      if (dout == UP) begin
        if (up_cnt == 0) first_up_floor = int'(cur_floor);
        up_cnt++;
      end
      if ((door_open && dout != ST) || dout == 2'b11) bad_cnt++;
      prev_door = door_open;
    end
  endtask

  function automatic int q_at(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Single trip 0->2, illegal end-floor requests, reset ignoring a request,
    // and a same-floor request absorbed while the door is open.
    tbl.push_back(mk(0, 1, 2, 0, ST, 0, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, UP, 0, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, UP, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, ST, 2, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, ST, 2, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, ST, 2, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, ST, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, ST, 2, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, ST, 2, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, ST, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2, 0, ST, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, ST, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, ST, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, ST, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, ST, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, ST, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, ST, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, ST, 0, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1 check("reset_state", obs(), {ST, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // Requests beyond the top floor only exist on the 5-floor car.
    @(negedge clk); r5_valid = 1'b1; r5_floor = 3'd5; r5_dir = 1'b0;
    @(posedge clk); #1 check("r5_floor5_err", r5_err, 1'b1);
    @(negedge clk); r5_floor = 3'd7; r5_dir = 1'b1;
    @(posedge clk); #1 check("r5_floor7_err", r5_err, 1'b1);
    @(negedge clk); r5_floor = 3'd4; r5_dir = 1'b0;
    @(posedge clk); #1 check("r5_top_up_err", r5_err, 1'b1);
    check("r5_no_pend", r5_busy, 1'b0);
    @(negedge clk); r5_floor = 3'd4; r5_dir = 1'b1;
    @(posedge clk); #1 check("r5_top_dn_ok", r5_err, 1'b0);
    check("r5_pend_set", r5_busy, 1'b1);
    @(negedge clk); r5_valid = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n     = !tbl[i].rst;
      req_valid = tbl[i].vld;
      req_floor = tbl[i].fl;
      req_dir   = tbl[i].dr;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), obs(),
            {tbl[i].dout, tbl[i].floor, tbl[i].door, tbl[i].done, tbl[i].err, tbl[i].busy});
    end
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;

    // Stop at 1 on the way up, then run to 3 and turn around there.
    do_reset();
    send(2'd1, 1'b0);
    send(2'd3, 1'b1);
    monitor(60);
    check("s2_nstops", stop_floor.size(), 2);
    check("s2_stop0", q_at(stop_floor, 0), 1);
    check("s2_stop1", q_at(stop_floor, 1), 3);
    check("s2_door0", q_at(door_len, 0), 3);
    check("s2_door1", q_at(door_len, 1), 3);
    check("s2_done", done_cnt, 2);
    check("s2_invariant", bad_cnt, 0);
    check("s2_idle", {dout, busy}, {ST, 1'b0});

    // A down call at 1 placed while sweeping up is served on the way back.
    do_reset();
    send(2'd3, 1'b1);
    @(posedge clk); #1 check("s3_moving_up", dout, UP);
    send(2'd1, 1'b1);
    monitor(80);
    check("s3_nstops", stop_floor.size(), 2);
    check("s3_stop0", q_at(stop_floor, 0), 3);
    check("s3_stop1", q_at(stop_floor, 1), 1);
    check("s3_done", done_cnt, 2);
    check("s3_idle", {dout, busy}, {ST, 1'b0});

    // Reset between floors 1 and 2, then a fresh single-floor trip from 0.
    do_reset();
    send(2'd2, 1'b0);
    begin
      int waited;
      waited = 0;
      while (cur_floor != 2'd1 && waited < 30) begin
        @(posedge clk); #1;
        waited++;
      end
      check("s4_reach_floor1", cur_floor, 2'd1);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 check("s4_async_reset", obs(), {ST, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1 check("s4_held_reset", obs(), {ST, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    send(2'd1, 1'b0);
    monitor(20);
    check("s4_up_cycles", up_cnt, 4);
    check("s4_from_floor0", first_up_floor, 0);
    check("s4_stop", q_at(stop_floor, 0), 1);
    check("s4_done", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lift_sched_fsm.md
LIFT_SCHED_FSM -- requirements
Module: lift_sched_fsm

Interface
REQ-001 SHALL have parameter FLOORS, default 4, number of floors; legal range 2..16.
REQ-002 SHALL have parameter TRAVEL_CYC, default 4, clock cycles per one-floor move; must be at least 1.
REQ-003 SHALL have parameter DOOR_CYC, default 3, clock cycles the door stays open; must be at least 1.
REQ-004 SHALL have derived localparam FW = max(1, clog2(FLOORS)), the floor index width.
REQ-005 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have port req_valid  in  1  a hall/car request is present this cycle.
REQ-008 SHALL have port req_floor  in  FW  target floor of the request.
REQ-009 SHALL have port req_dir  in  1  requested travel direction, 0=UP, 1=DOWN.
REQ-010 SHALL have port req_err  out  1  one-cycle pulse, request rejected.
REQ-011 SHALL have port dout  out  2  motor command, 00=UP, 01=DOWN, 10=STAY; 11 is never driven.
REQ-012 SHALL have port cur_floor  out  FW  current car floor.
REQ-013 SHALL have port door_open  out  1  door open indication.
REQ-014 SHALL have port done  out  1  one-cycle pulse, a stop has been fully serviced.
REQ-015 SHALL have port busy  out  1  high whenever the state is not IDLE or any request is pending.

Function
REQ-016 SHALL hold pending bitmaps up_pend[FLOORS] and dn_pend[FLOORS] plus a direction register dir; the initial value of dir is UP.
REQ-017 SHALL apply a sampled request (req_valid=1 at a clock edge) as follows:
- sets up_pend[req_floor] when req_dir=0, or dn_pend[req_floor] when req_dir=1;
- the bit is visible in the next cycle;
- repeated requests are idempotent.
REQ-018 SHALL reject a request without changing state and pulse req_err in the following cycle when any of these holds:
- req_floor >= FLOORS;
- UP requested at floor FLOORS-1;
- DOWN requested at floor 0.
REQ-019 SHALL implement exactly three states: IDLE, MOVE and DOOR.
REQ-020 SHALL evaluate IDLE in this priority order:
- if any pending bit at cur_floor, go to DOOR;
- else if any bit is pending above cur_floor and (dir=UP or nothing is pending below), set dir=UP and go to MOVE;
- else if anything is pending below, set dir=DOWN and go to MOVE;
- else stay in IDLE.
REQ-021 SHALL in MOVE count TRAVEL_CYC cycles, then on the terminal cycle step cur_floor by +1 (UP) or -1 (DOWN) and reset the counter.
REQ-022 SHALL, after a MOVE step, go to DOOR at the new floor if either of these holds:
- the pending bit for dir is set there;
- no request is pending beyond that floor in dir, in which case dir flips and both bits at that floor are served.
Otherwise MOVE continues.
REQ-023 SHALL never step cur_floor beyond 0 or FLOORS-1; the end floors always force a stop or an IDLE evaluation.
REQ-024 SHALL on DOOR entry clear the served bit(s) at cur_floor, then hold door_open=1 for exactly DOOR_CYC cycles; on the last of them return to IDLE and pulse done for one cycle.
REQ-025 SHALL silently absorb a request arriving during DOOR for cur_floor in the served direction: no bit is set, the timer is not restarted and req_err stays low.
REQ-026 SHALL drive dout=UP or DOWN only in MOVE, according to dir, and dout=STAY in IDLE and DOOR.
REQ-027 SHALL keep door_open=0 in MOVE under all conditions.
REQ-028 SHALL, when a request and a clear of the same bit fall on the same edge, leave the clear winning only if the request is absorbed per REQ-025; otherwise the request wins.

Reset
REQ-029 SHALL, on rst_n=0 at any time, immediately force: state=IDLE, cur_floor=0, dir=UP, all pending bits 0, counters 0, dout=STAY, door_open=0, done=0, req_err=0, busy=0.
REQ-030 SHALL on reset mid-MOVE abandon the trip, with the car logically at floor 0 after release.
REQ-031 SHALL ignore requests while rst_n=0.

Verification (FLOORS=4, TRAVEL_CYC=4, DOOR_CYC=3)
REQ-032 SHALL cover: after reset, request floor 2 UP -> dout=UP for 8 cycles, cur_floor 0->1->2, door_open for 3 cycles, one done pulse, dout=STAY, busy=0.
REQ-033 SHALL cover: car at floor 0, requests 3 DOWN and 1 UP on one cycle -> stop at 1 (door 3 cycles), then continue to 3, dir becomes DOWN, stop, done pulses twice.
REQ-034 SHALL cover: while moving UP from 0 toward 3, request floor 1 DOWN -> no stop at 1; after serving 3, the car travels DOWN to 1 and stops.
REQ-035 SHALL cover: requests floor 3 UP, floor 0 DOWN and floor 5 -> req_err pulses 3 times, no pending bits set, dout stays STAY.
REQ-036 SHALL cover: request floor 0 UP while idle at floor 0 -> DOOR next cycle, no MOVE; the same request repeated during DOOR is absorbed and no second done pulse occurs.
REQ-037 SHALL cover: rst_n asserted mid-MOVE between floors 1 and 2 -> all outputs at reset values immediately; after release, a request for floor 1 UP produces a 4-cycle UP move from floor 0.
